// File: rtl/picobello_mesh_link_fabric.sv
// picobello_mesh_link_fabric: joins each tile router port to the opposite port of its mesh neighbour.
// Latency: LinkStages cycles per hop (0 = combinational passthrough). Boundary ports sink and count flits.
// Backpressure: valid/ready per link; spill stages register ready, so in_ready_i never reaches out_ready_o combinationally.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   out_valid_i/out_ready_o/out_data_i   tile -> fabric, P = MeshX*MeshY*4*NumChan ports
//   in_valid_o/in_ready_i/in_data_o      fabric -> tile
//   drop_clr_i                   synchronous clear of drop counters and drop_err_o
//   drop_cnt_o, drop_err_o       per-channel saturating boundary-drop count, sticky drop flag
//   perf_flits_o                 per-channel delivered-flit count, only when PB_MESH_LINK_PERF_EN is defined
// Port index: ((x*MeshY + y)*4 + dir)*NumChan + ch, dir N=0 E=1 S=2 W=3.
// Optional feature macro: PB_MESH_LINK_PERF_EN (delivered-flit counters; tied to 0 when undefined).

// One elastic hop stage: 2-entry spill register.
// Latency: 1 cycle. Backpressure: ready is a function of the registered fill state only.
module pb_mesh_spill_stage #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] head_q, head_d;
    logic [DataWidth-1:0] tail_q, tail_d;
    logic                 push, pop;

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push    = in_valid_i && (state_q != TWO);
        pop     = (state_q != EMPTY) && out_ready_i;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d  = in_data_i;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // The second entry moves to the head; no push is accepted this cycle.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
endmodule

module picobello_mesh_link_fabric #(
    parameter int unsigned MeshX      = 4,
    parameter int unsigned MeshY      = 4,
    parameter int unsigned NumChan    = 3,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned LinkStages = 1,
    parameter int unsigned DropCntW   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [MeshX*MeshY*4*NumChan-1:0]           out_valid_i,
    output logic [MeshX*MeshY*4*NumChan-1:0]           out_ready_o,
    input  logic [MeshX*MeshY*4*NumChan*DataWidth-1:0] out_data_i,
    output logic [MeshX*MeshY*4*NumChan-1:0]           in_valid_o,
    input  logic [MeshX*MeshY*4*NumChan-1:0]           in_ready_i,
    output logic [MeshX*MeshY*4*NumChan*DataWidth-1:0] in_data_o,
    input  logic                                  drop_clr_i,
    output logic [NumChan*DropCntW-1:0]           drop_cnt_o,
    output logic                                  drop_err_o,
    output logic [NumChan*32-1:0]                 perf_flits_o
);
    localparam int unsigned NumTilePorts = MeshX * MeshY * 4;
    localparam int unsigned SumW         = DropCntW + 32;
    localparam logic [DropCntW-1:0] CntMax = '1;

    // Per channel, one bit per tile port: valid on a port that leads off-mesh.
    logic [NumChan-1:0][NumTilePorts-1:0] bnd_vld;
`ifdef PB_MESH_LINK_PERF_EN
    // Per channel, one bit per tile port: handshake on the fabric->tile side.
    logic [NumChan-1:0][NumTilePorts-1:0] dlv;
`endif

    for (genvar gx = 0; gx < MeshX; gx++) begin : g_x
        for (genvar gy = 0; gy < MeshY; gy++) begin : g_y
            for (genvar gd = 0; gd < 4; gd++) begin : g_d
                for (genvar gc = 0; gc < NumChan; gc++) begin : g_c
                    localparam int unsigned TPort = (gx * MeshY + gy) * 4 + gd;
                    localparam int unsigned Idx   = TPort * NumChan + gc;
                    localparam bit Bnd = (gd == 0 && gy == MeshY - 1) || (gd == 1 && gx == MeshX - 1) ||
                                         (gd == 2 && gy == 0)         || (gd == 3 && gx == 0);
                    if (Bnd) begin : g_bnd
                        // Off-mesh: sink every flit, never present one. The inbound side of the
                        // same port has no source, so its ready and the outbound data are ignored.
                        logic unused_bnd;
                        assign unused_bnd = ^{out_data_i[Idx*DataWidth +: DataWidth], in_ready_i[Idx]};
                        assign out_ready_o[Idx]                       = 1'b1;
                        assign in_valid_o[Idx]                        = 1'b0;
                        assign in_data_o[Idx*DataWidth +: DataWidth]  = '0;
                        assign bnd_vld[gc][TPort]                     = out_valid_i[Idx];
`ifdef PB_MESH_LINK_PERF_EN
                        assign dlv[gc][TPort]                         = 1'b0;
`endif
                    end else begin : g_link
                        localparam int NX = (gd == 1) ? gx + 1 : (gd == 3) ? gx - 1 : gx;
                        localparam int NY = (gd == 0) ? gy + 1 : (gd == 2) ? gy - 1 : gy;
                        localparam int unsigned DstPort = (NX * MeshY + NY) * 4 + (gd + 2) % 4;
                        localparam int unsigned Dst     = DstPort * NumChan + gc;

                        logic [LinkStages:0]                vld;
                        logic [LinkStages:0]                rdy;
                        logic [LinkStages:0][DataWidth-1:0] dat;

                        assign vld[0]           = out_valid_i[Idx];
                        assign dat[0]           = out_data_i[Idx*DataWidth +: DataWidth];
                        assign out_ready_o[Idx] = rdy[0];
                        assign bnd_vld[gc][TPort] = 1'b0;

                        for (genvar gs = 0; gs < LinkStages; gs++) begin : g_stage
                            pb_mesh_spill_stage #(.DataWidth(DataWidth)) u_stage (
                                .clk_i      (clk_i),
                                .rst_i      (rst_i),
                                .in_valid_i (vld[gs]),
                                .in_ready_o (rdy[gs]),
                                .in_data_i  (dat[gs]),
                                .out_valid_o(vld[gs+1]),
                                .out_ready_i(rdy[gs+1]),
                                .out_data_o (dat[gs+1])
                            );
                        end

                        assign in_valid_o[Dst]                       = vld[LinkStages];
                        assign in_data_o[Dst*DataWidth +: DataWidth] = dat[LinkStages];
                        assign rdy[LinkStages]                       = in_ready_i[Dst];
`ifdef PB_MESH_LINK_PERF_EN
                        assign dlv[gc][DstPort] = vld[LinkStages] & in_ready_i[Dst];
`endif
                    end
                end
            end
        end
    end

    logic drop_err_q, drop_err_d;

    always_comb begin
        drop_err_d = drop_err_q;
        if (|bnd_vld)   drop_err_d = 1'b1;
        if (drop_clr_i) drop_err_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_err_q <= 1'b0;
        else       drop_err_q <= drop_err_d;
    end

    assign drop_err_o = drop_err_q;

    for (genvar gc = 0; gc < NumChan; gc++) begin : g_chan
        logic [DropCntW-1:0] cnt_q, cnt_d;
        logic [SumW-1:0]     sum;

        // Wide sum so that several drops in one cycle saturate instead of wrapping.
        always_comb begin
            sum   = SumW'(cnt_q) + SumW'($countones(bnd_vld[gc]));
            cnt_d = (sum > SumW'(CntMax)) ? CntMax : sum[DropCntW-1:0];
            if (drop_clr_i) cnt_d = '0;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign drop_cnt_o[gc*DropCntW +: DropCntW] = cnt_q;

`ifdef PB_MESH_LINK_PERF_EN
        logic [31:0] perf_q, perf_d;

        always_comb begin
            perf_d = perf_q + 32'($countones(dlv[gc]));
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) perf_q <= '0;
            else       perf_q <= perf_d;
        end

        assign perf_flits_o[gc*32 +: 32] = perf_q;
`else
        assign perf_flits_o[gc*32 +: 32] = '0;
`endif
    end
endmodule

// File: tb/tb_picobello_mesh_link_fabric.sv
// Bench for picobello_mesh_link_fabric: directed link/drop/reset steps plus randomized traffic
// scored against a per-link FIFO model derived from the mesh neighbour rules.
`timescale 1ns/1ps
module tb_picobello_mesh_link_fabric;
    localparam int MX = 3, MY = 3, NC = 3, DW = 16, LS = 2, DCW = 4;
    localparam int P    = MX * MY * 4 * NC;
    localparam int MAXC = (1 << DCW) - 1;
    localparam int P1   = 2 * 2 * 4;
`ifdef PB_MESH_LINK_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [P-1:0]      ov, ordy, iv, ir;
    logic [P*DW-1:0]   od, id;
    logic              clr, derr;
    logic [NC*DCW-1:0] dcnt;
    logic [NC*32-1:0]  perf;

    logic [P1-1:0]     ov1, ordy1, iv1, ir1;
    logic [P1*8-1:0]   od1, id1;
    logic [15:0]       dcnt1;
    logic              derr1;
    logic [31:0]       perf1;

    picobello_mesh_link_fabric #(.MeshX(MX), .MeshY(MY), .NumChan(NC), .DataWidth(DW),
                                 .LinkStages(LS), .DropCntW(DCW)) dut (
        .clk_i(clk), .rst_i(rst),
        .out_valid_i(ov), .out_ready_o(ordy), .out_data_i(od),
        .in_valid_o(iv), .in_ready_i(ir), .in_data_o(id),
        .drop_clr_i(clr), .drop_cnt_o(dcnt), .drop_err_o(derr), .perf_flits_o(perf)
    );

    picobello_mesh_link_fabric #(.MeshX(2), .MeshY(2), .NumChan(1), .DataWidth(8),
                                 .LinkStages(1), .DropCntW(16)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .out_valid_i(ov1), .out_ready_o(ordy1), .out_data_i(od1),
        .in_valid_o(iv1), .in_ready_i(ir1), .in_data_o(id1),
        .drop_clr_i(1'b0), .drop_cnt_o(dcnt1), .drop_err_o(derr1), .perf_flits_o(perf1)
    );

    typedef struct { int dst; logic [DW-1:0] dat; } fl_t;
    fl_t        sb[$];
    int         mcnt[NC];
    bit         merr;
    int         mperf[NC];
    logic [P-1:0] bmask, acc;
    int         n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pidx(int x, int y, int d, int c);
        return ((x * MY + y) * 4 + d) * NC + c;
    endfunction

    function automatic bit off_mesh(int x, int y, int d);
        return (d == 0 && y == MY - 1) || (d == 1 && x == MX - 1) || (d == 2 && y == 0) || (d == 3 && x == 0);
    endfunction

    // Receiving port of the link driven by sender port i.
    function automatic int dst_of(int i);
        int c = i % NC, d = (i / NC) % 4, t = i / (NC * 4);
        int x = t / MY, y = t % MY;
        if (d == 0) y++; else if (d == 1) x++; else if (d == 2) y--; else x--;
        return pidx(x, y, (d + 2) % 4, c);
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int c = 0; c < NC; c++) begin mcnt[c] = 0; mperf[c] = 0; end
        merr = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; scores this cycle and advances to the next negedge.
    task automatic step();
        logic [P-1:0]    r_save;
        logic [DW-1:0]   bz;
        int              nb[NC];
        bit              found;
        acc = '0;
        bz  = '0;
        #1;
        r_save = ordy; ir = ~ir; #1;
        check("ready_path", ordy, r_save);
        ir = ~ir; #1;
        check("bnd_in_valid", iv & bmask, '0);
        check("bnd_out_ready", ordy & bmask, bmask);
        for (int i = 0; i < P; i++) if (bmask[i]) bz |= id[i*DW +: DW];
        check("bnd_in_data", bz, '0);
        for (int c = 0; c < NC; c++) begin
            check("drop_cnt", dcnt[c*DCW +: DCW], mcnt[c]);
            check("perf", perf[c*32 +: 32], PERF ? mperf[c] : 0);
            nb[c] = 0;
        end
        check("drop_err", derr, merr);
        for (int i = 0; i < P; i++) begin
            if (iv[i] && ir[i]) begin
                found = 1'b0;
                for (int k = 0; k < sb.size() && !found; k++) begin
                    if (sb[k].dst == i) begin
                        found = 1'b1;
                        check("link_data", id[i*DW +: DW], sb[k].dat);
                        sb.delete(k);
                    end
                end
                if (!found) begin
                    n_cmp++; n_bad++;
                    $error("FAIL unexpected_flit: port %0d observed %0h expected none", i, id[i*DW +: DW]);
                end
                mperf[i % NC]++;
            end
        end
        for (int i = 0; i < P; i++) begin
            if (ov[i] && ordy[i]) begin
                acc[i] = 1'b1;
                if (bmask[i]) nb[i % NC]++;
                else sb.push_back('{dst_of(i), od[i*DW +: DW]});
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (clr) mcnt[c] = 0;
            else mcnt[c] = (mcnt[c] + nb[c] > MAXC) ? MAXC : mcnt[c] + nb[c];
            if (!clr && nb[c] > 0) merr = 1'b1;
        end
        if (clr) merr = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_src(int pct);
        for (int i = 0; i < P; i++) begin
            if (acc[i] || !ov[i]) begin
                ov[i] = ($urandom_range(99) < (bmask[i] ? 5 : pct));
                od[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    initial begin
        int s, s2, d, sent, sent2, got, budget;
        logic [P1-1:0] exp1;

        rst = 1'b1; clr = 1'b0;
        ov = '0; od = '0; ir = '1; ov1 = '0; od1 = '0; ir1 = '1; acc = '0;
        for (int x = 0; x < MX; x++) for (int y = 0; y < MY; y++) for (int dd = 0; dd < 4; dd++)
            for (int c = 0; c < NC; c++) bmask[pidx(x, y, dd, c)] = off_mesh(x, y, dd);
        model_reset();

        // Reset state.
        @(negedge clk); #1;
        check("rst_in_valid", iv, '0);
        check("rst_in_data", |id, 1'b0);
        check("rst_out_ready", ordy, {P{1'b1}});
        check("rst_drop_cnt", dcnt, '0);
        check("rst_drop_err", derr, 1'b0);
        check("rst_perf", perf, '0);
        check("rst1_out_ready", ordy1, {P1{1'b1}});
        check("rst1_in_valid", iv1, '0);
        @(negedge clk); rst = 1'b0;

        // 2x2, one stage: (0,0) E sends 0xA5 once, (1,0) W sees it exactly one cycle later for one cycle.
        ov1[1] = 1'b1; od1[1*8 +: 8] = 8'hA5; #1;
        check("lat_before", iv1, '0);
        @(negedge clk); ov1 = '0; #1;
        exp1 = '0; exp1[11] = 1'b1;
        check("lat_valid", iv1, exp1);
        check("lat_data", id1[11*8 +: 8], 8'hA5);
        @(negedge clk); #1;
        check("lat_after", iv1, '0);
        @(negedge clk);

        // Stall: sink of (0,0)E link not ready for 10 cycles while the source streams 1,2,3,...
        s = pidx(0, 0, 1, 0); d = dst_of(s);
        sent = 0; ir = '1; ir[d] = 1'b0;
        ov[s] = 1'b1; od[s*DW +: DW] = DW'(1);
        for (int k = 0; k < 10; k++) begin
            step();
            if (acc[s]) begin sent++; od[s*DW +: DW] = DW'(sent + 1); end
        end
        check("stall_accepts", sent, 2 * LS);
        check("stall_ready", ordy[s], 1'b0);
        ir[d] = 1'b1; got = 0;
        for (int k = 0; k < 12; k++) begin
            #1; if (iv[d]) got++;
            step();
            if (acc[s]) begin sent++; od[s*DW +: DW] = DW'(sent + 1); end
        end
        check("stream_rate", got, 12);
        ov[s] = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("stall_drained", sb.size(), 0);

        // Boundary drops: (0,0) S and (0,0) W on ch1 in the same cycle.
        clr = 1'b1; step(); clr = 1'b0;
        ov[pidx(0, 0, 2, 1)] = 1'b1; ov[pidx(0, 0, 3, 1)] = 1'b1;
        step();
        ov = '0; #1;
        check("drop_two", dcnt[1*DCW +: DCW], 2);
        check("drop_err_set", derr, 1'b1);
        ov[pidx(0, 0, 3, 1)] = 1'b1; clr = 1'b1;
        step();
        ov = '0; clr = 1'b0; #1;
        check("drop_clr_prio", dcnt, '0);
        check("drop_err_clr", derr, 1'b0);

        // Saturation: 20 boundary flits on ch0.
        ov[pidx(0, 0, 3, 0)] = 1'b1;
        for (int k = 0; k < 20; k++) step();
        ov = '0; #1;
        check("drop_sat", dcnt[0 +: DCW], MAXC);
        step();

        // Randomized traffic, random sink readiness and occasional clears.
        for (int k = 0; k < 300; k++) begin
            rand_src(60);
            for (int i = 0; i < P; i++) ir[i] = ($urandom_range(1) == 1);
            clr = ($urandom_range(99) < 3);
            step();
        end
        clr = 1'b0;

        // Reset mid-stream: pipes empty and counters clear at once.
        rand_src(60);
        #2 rst = 1'b1; #1;
        check("mid_rst_in_valid", iv, '0);
        check("mid_rst_drop", dcnt, '0);
        check("mid_rst_err", derr, 1'b0);
        check("mid_rst_perf", perf, '0);
        model_reset();
        @(negedge clk); rst = 1'b0; ov = '0; acc = '0; ir = '1;
        #1;
        check("post_rst_ready", ordy, {P{1'b1}});

        // Delivered-flit counters: 7 flits on ch0 and 3 on ch2.
        s = pidx(1, 1, 0, 0); s2 = pidx(1, 1, 0, 2);
        sent = 0; sent2 = 0;
        ov[s] = 1'b1; od[s*DW +: DW] = DW'($urandom);
        ov[s2] = 1'b1; od[s2*DW +: DW] = DW'($urandom);
        for (int k = 0; k < 20; k++) begin
            step();
            if (acc[s])  begin sent++;  od[s*DW +: DW]  = DW'($urandom); end
            if (acc[s2]) begin sent2++; od[s2*DW +: DW] = DW'($urandom); end
            ov[s]  = (sent < 7);
            ov[s2] = (sent2 < 3);
        end
        #1;
        check("perf_vec", perf, PERF ? {32'd3, 32'd0, 32'd7} : 96'd0);

        // Final drain of whatever is left.
        ov = '0; ir = '1; budget = 0;
        while (sb.size() != 0 && budget < 50) begin step(); budget++; end
        check("final_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
